serial_host_port: RTL and testbench

//  CPU-side initiator for the byte-serial UART core's toggle handshake.

---
 rtl/serial_host_pkg.sv | 16 +
 rtl/sync_fifo.sv | 35 +++
 rtl/serial_host_port.sv | 81 ++++++++
 tb/tb_serial_host_port.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/serial_host_pkg.sv
// serial_host_pkg: register map, status/control bit positions and TX FSM states
package serial_host_pkg;
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;
  localparam int ST_RX_AVAIL = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_TX_IDLE  = 2;
  localparam int ST_RX_OVR   = 3;
  localparam int ST_TX_DROP  = 4;
  localparam int CT_RX_IE = 0;
  localparam int CT_TX_IE = 1;
  localparam logic [7:0] CTRL_MASK = 8'h03;
  typedef enum logic {TX_IDLE, TX_WAIT} tx_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with extra-MSB pointers; accepts push at full when popping
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign empty   = wp == rp;
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/serial_host_port.sv
// serial_host_port: CPU register port bridging TX/RX FIFOs to a UART req/ack toggle handshake
module serial_host_port
  import serial_host_pkg::*;
#(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sel,
  input  logic       wr,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       irq,
  output logic [7:0] tx_data,
  output logic       tx_req,
  input  logic       tx_ack,
  input  logic [7:0] rx_data,
  input  logic       rx_tgl
);
  tx_state_e state;
  logic [7:0] ctrl, status, rd_val, tx_head, rx_head;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic rx_tgl_d, rx_ovr, tx_drop;
  logic rd_en, wr_en, stat_rd, tx_push, tx_pop, rx_push, rx_pop, tx_idle;
  assign rd_en   = sel & ~wr;
  assign wr_en   = sel & wr;
  assign stat_rd = rd_en & (addr == ADDR_STATUS);
  assign tx_push = wr_en & (addr == ADDR_DATA) & ~tx_full;
  assign tx_pop  = (state == TX_IDLE) & ~tx_empty;
  assign rx_push = rx_tgl ^ rx_tgl_d;
  assign rx_pop  = rd_en & (addr == ADDR_DATA) & ~rx_empty;
  assign tx_idle = tx_empty & (state == TX_IDLE);
  always_comb begin
    status = '0;
    status[ST_RX_AVAIL] = ~rx_empty;
    status[ST_TX_FULL]  = tx_full;
    status[ST_TX_IDLE]  = tx_idle;
    status[ST_RX_OVR]   = rx_ovr;
    status[ST_TX_DROP]  = tx_drop;
  end
  assign rd_val = (addr == ADDR_RSVD)   ? 8'h00 :
                  (addr == ADDR_STATUS) ? status :
                  (addr == ADDR_CTRL)   ? ctrl :
                  rx_empty ? 8'h00 : rx_head;
  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(tx_pop), .din(wdata),
    .full(tx_full), .empty(tx_empty), .head(tx_head)
  );
  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_push), .pop(rx_pop), .din(rx_data),
    .full(rx_full), .empty(rx_empty), .head(rx_head)
  );
  // UART toggles are unreset, so equalise our side to them on reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata    <= '0;
      irq      <= 1'b0;
      tx_data  <= '0;
      tx_req   <= tx_ack;
      rx_tgl_d <= rx_tgl;
      state    <= TX_IDLE;
      ctrl     <= '0;
      rx_ovr   <= 1'b0;
      tx_drop  <= 1'b0;
    end else begin
      rx_tgl_d <= rx_tgl;
      if (rd_en) rdata <= rd_val;
      if (wr_en && addr == ADDR_CTRL) ctrl <= wdata & CTRL_MASK;
      rx_ovr  <= (rx_push & rx_full & ~rx_pop) | (rx_ovr & ~stat_rd);
      tx_drop <= (wr_en & (addr == ADDR_DATA) & tx_full) | (tx_drop & ~stat_rd);
      irq     <= (ctrl[CT_RX_IE] & ~rx_empty) | (ctrl[CT_TX_IE] & tx_idle);
      if (tx_pop) begin
        tx_data <= tx_head;
        tx_req  <= ~tx_req;
        state   <= TX_WAIT;
      end else if (state == TX_WAIT && tx_ack == tx_req) state <= TX_IDLE;
    end
  end
endmodule

// File: tb/tb_serial_host_port.sv
// tb_serial_host_port: queue-based reference model with per-cycle compare, directed and random traffic
module tb_serial_host_port;
  localparam int D = 16;
  logic clk = 0, rst_n = 0, sel = 0, wr = 0;
  logic [1:0] addr = 0;
  logic [7:0] wdata = 0, rx_data = 0, rdata, tx_data, d;
  logic tx_ack = 1, rx_tgl = 1, irq, tx_req;
  int checks = 0, errors = 0;
  serial_host_port #(.TX_DEPTH(D), .RX_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .irq(irq), .tx_data(tx_data), .tx_req(tx_req), .tx_ack(tx_ack),
    .rx_data(rx_data), .rx_tgl(rx_tgl)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask
  // reference model: FIFOs as queues, one transfer-in-flight flag
  logic [7:0] q_tx[$], q_rx[$];
  logic busy = 0, m_irq = 0, m_req = 0, m_rxd = 0, m_ovr = 0, m_drop = 0;
  logic [7:0] m_rdata = 0, m_tx_data = 0;
  logic [1:0] m_ctrl = 0;
  task automatic model_step();
    int ntx, nrx;
    logic idle, rx_pop, oset, dset;
    if (!rst_n) begin
      q_tx.delete(); q_rx.delete();
      busy = 0; m_irq = 0; m_rdata = 0; m_tx_data = 0; m_ctrl = 0;
      m_ovr = 0; m_drop = 0; m_req = tx_ack; m_rxd = rx_tgl;
      return;
    end
    ntx = q_tx.size(); nrx = q_rx.size();
    idle = (ntx == 0) && !busy;
    oset = 0; dset = 0;
    rx_pop = sel && !wr && addr == 0 && nrx > 0;
    m_irq = (m_ctrl[0] && nrx > 0) || (m_ctrl[1] && idle);
    if (sel && !wr)
      m_rdata = addr == 0 ? (nrx > 0 ? q_rx[0] : 8'h00) :
                addr == 1 ? {3'b0, m_drop, m_ovr, idle, ntx == D, nrx > 0} :
                addr == 2 ? {6'b0, m_ctrl} : 8'h00;
    if (!busy && ntx > 0) begin
      m_tx_data = q_tx.pop_front();
      m_req = ~m_req;
      busy = 1;
    end else if (busy && tx_ack == m_req) busy = 0;
    if (sel && wr && addr == 0) begin
      if (ntx == D) dset = 1;
      else q_tx.push_back(wdata);
    end
    if (sel && wr && addr == 2) m_ctrl = wdata[1:0];
    if (rx_pop) q_rx.delete(0);
    if (rx_tgl !== m_rxd) begin
      if (nrx < D || rx_pop) q_rx.push_back(rx_data);
      else oset = 1;
    end
    m_rxd = rx_tgl;
    if (sel && !wr && addr == 1) begin m_ovr = 0; m_drop = 0; end
    m_ovr = m_ovr | oset;
    m_drop = m_drop | dset;
  endtask
  always @(posedge clk) model_step();
  logic chk_on = 0;
  always @(negedge clk)
    if (chk_on) begin
      chk("rdata", rdata, m_rdata);
      chk("irq", {7'b0, irq}, {7'b0, m_irq});
      chk("tx_data", tx_data, m_tx_data);
      chk("tx_req", {7'b0, tx_req}, {7'b0, m_req});
    end
  // UART-side acknowledger with programmable latency
  logic ack_en = 0;
  int ack_dly = 0, cnt = 0;
  always @(negedge clk)
    if (!ack_en) cnt = 0;
    else if (tx_req !== tx_ack) begin
      if (cnt >= ack_dly) begin tx_ack = ~tx_ack; cnt = 0; end
      else cnt++;
    end
  int ntog = 0;
  logic prev_req = 0;
  logic [7:0] first_data = 0, last_data = 0;
  always @(negedge clk) begin
    if (rst_n && tx_req !== prev_req) begin
      ntog++;
      if (ntog == 1) first_data = tx_data;
      last_data = tx_data;
    end
    prev_req = tx_req;
  end
  task automatic bus_wr(input logic [1:0] a, input logic [7:0] v);
    sel = 1; wr = 1; addr = a; wdata = v;
    @(negedge clk);
    sel = 0; wr = 0;
    @(negedge clk);
  endtask
  task automatic bus_rd(input logic [1:0] a, output logic [7:0] v);
    sel = 1; wr = 0; addr = a;
    @(negedge clk);
    sel = 0;
    v = rdata;
    @(negedge clk);
  endtask
  task automatic rx_tog(input logic [7:0] v);
    rx_data = v; rx_tgl = ~rx_tgl;
    @(negedge clk);
  endtask
  task automatic wait_idle(input int limit);
    int n = 0;
    while ((q_tx.size() != 0 || busy) && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= limit) begin
      errors++;
      $display("FAIL idle_timeout actual=%0d required=<%0d", n, limit);
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk_on = 1;
    chk("reset_tx_req", {7'b0, tx_req}, 8'h01);
    rst_n = 1;
    @(negedge clk);
    bus_rd(1, d); chk("reset_status", d, 8'h04);
    bus_rd(0, d); chk("reset_rx_empty", d, 8'h00);
    ntog = 0; ack_dly = 20; ack_en = 1;
    bus_wr(0, 8'h55); bus_wr(0, 8'hAA);
    wait_idle(200);
    chk("two_toggles", ntog[7:0], 8'd2);
    chk("first_byte", first_data, 8'h55);
    chk("second_byte", last_data, 8'hAA);
    bus_rd(1, d); chk("idle_after_two", d, 8'h04);
    ack_en = 0; ntog = 0;
    for (int i = 0; i < 18; i++) bus_wr(0, 8'h10 + 8'(i));
    bus_rd(1, d); chk("status_drop_full", d, 8'h12);
    bus_rd(1, d); chk("status_drop_clr", d, 8'h02);
    chk("held_tx_data", tx_data, 8'h10);
    ack_dly = 2; ack_en = 1;
    wait_idle(600);
    chk("seventeen_toggles", ntog[7:0], 8'd17);
    chk("last_queued", last_data, 8'h20);
    rx_tog(8'h31); rx_tog(8'h32);
    bus_rd(0, d); chk("rx_first", d, 8'h31);
    bus_rd(0, d); chk("rx_second", d, 8'h32);
    bus_rd(0, d); chk("rx_empty_read", d, 8'h00);
    bus_rd(1, d); chk("rx_avail_clear", d, 8'h04);
    for (int i = 0; i < 17; i++) rx_tog(8'h40 + 8'(i));
    bus_rd(1, d); chk("rx_ovr_set", d, 8'h0D);
    sel = 1; wr = 0; addr = 0; rx_data = 8'hEE; rx_tgl = ~rx_tgl;
    @(negedge clk);
    sel = 0; d = rdata;
    chk("full_pop_push", d, 8'h40);
    @(negedge clk);
    bus_rd(1, d); chk("rx_ovr_unchanged", d, 8'h05);
    for (int i = 1; i < 16; i++) begin
      bus_rd(0, d); chk("rx_intact", d, 8'h40 + 8'(i));
    end
    bus_rd(0, d); chk("rx_late_byte", d, 8'hEE);
    bus_wr(2, 8'hFF);
    chk("irq_on", {7'b0, irq}, 8'h01);
    bus_rd(2, d); chk("ctrl_read", d, 8'h03);
    bus_wr(2, 8'h00);
    chk("irq_off", {7'b0, irq}, 8'h00);
    ack_en = 0;
    bus_wr(0, 8'h77);
    @(negedge clk);
    chk("req_pending", {7'b0, tx_req}, {7'b0, ~tx_ack});
    bus_wr(0, 8'h78);
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("req_eq_ack", {7'b0, tx_req}, {7'b0, tx_ack});
    chk("reset_tx_data", tx_data, 8'h00);
    bus_rd(1, d); chk("status_after_rst", d, 8'h04);
    ack_en = 1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        sel = 1; wr = 1'($urandom_range(0, 1)); addr = 2'($urandom_range(0, 3)); wdata = 8'($urandom);
      end else sel = 0;
      if ($urandom_range(0, 5) == 0) begin rx_data = 8'($urandom); rx_tgl = ~rx_tgl; end
      ack_dly = $urandom_range(0, 6);
      @(negedge clk);
    end
    sel = 0;
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
